// File: rtl/mem_resp_queue.sv
// In-order MEM-stage response queue: holds in-flight loads until their data_ok returns,
// aligns the loaded data and hands completed entries downstream; flush drains late responses.
module mem_resp_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic                 in_wait_data,
  input  logic [2:0]           in_op,
  input  logic [1:0]           in_addr_low,
  input  logic                 in_gr_we,
  input  logic [31:0]          in_alu_result,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 data_ok,
  input  logic [31:0]          rdata,
  output logic                 out_valid,
  input  logic                 out_allowin,
  output logic [31:0]          out_result,
  output logic [3:0]           out_rf_we,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 flush,
  output logic                 full,
  output logic                 empty,
  output logic                 resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  logic [AW-1:0]        head, tail, resp_idx, scan_idx;
  logic [CW-1:0]        count, drop_cnt, pend_cnt, drop_load;
  logic [SW-1:0]        drop_sum;
  logic [DEPTH-1:0]     pending;
  logic [DEPTH-1:0]     gr_we_q;
  logic [2:0]           op_q      [DEPTH];
  logic [1:0]           addr_q    [DEPTH];
  logic [31:0]          data_q    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];

  logic push_try, push, pop, resp_found, drop_take, complete, unexpected;
  logic [31:0] h_data;
  logic [1:0]  h_addr;
  logic [7:0]  h_byte;
  logic [15:0] h_half;

  assign empty      = !resetn || (count == '0);
  assign full       = resetn && (count == CW'(DEPTH));
  assign out_valid  = resetn && (count != '0) && !pending[head];
  assign in_allowin = !full || (out_valid && out_allowin);

  assign push_try   = in_valid && in_allowin;
  assign push       = push_try && !flush;
  assign pop        = out_valid && out_allowin;
  assign drop_take  = data_ok && (drop_cnt != '0);
  assign complete   = data_ok && !drop_take && resp_found;
  assign unexpected = data_ok && !drop_take && !resp_found;

  // The oldest pending entry is the one the next response belongs to.
  always_comb begin
    resp_found = 1'b0;
    resp_idx   = head;
    scan_idx   = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + AW'(i);
      if (!resp_found && pending[scan_idx]) begin
        resp_found = 1'b1;
        resp_idx   = scan_idx;
      end
    end
  end

  // Responses still owed after a flush: earlier drops, surviving pending entries and a
  // pending push that is being refused, minus whatever this cycle's data_ok retires.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt = pend_cnt + CW'(pending[i]);
    end
    drop_sum  = SW'(drop_cnt) + SW'(pend_cnt) + SW'(push_try && in_wait_data)
              - SW'(drop_take) - SW'(complete);
    drop_load = (drop_sum > SW'(DEPTH)) ? CW'(DEPTH) : drop_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pending  <= '0;
      drop_cnt <= '0;
      resp_err <= 1'b0;
    end else begin
      if (unexpected) begin
        resp_err <= 1'b1;
      end
      if (flush) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        pending  <= '0;
        drop_cnt <= drop_load;
      end else begin
        if (drop_take) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (complete) begin
          pending[resp_idx] <= 1'b0;
        end
        if (push) begin
          pending[tail] <= in_wait_data;
          tail          <= tail + AW'(1);
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Entry storage needs no reset; the pending flags and count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[tail]      <= in_op;
      addr_q[tail]    <= in_addr_low;
      gr_we_q[tail]   <= in_gr_we;
      data_q[tail]    <= in_alu_result;
      payload_q[tail] <= in_payload;
    end
    if (complete && (op_q[resp_idx] != 3'd7)) begin
      data_q[resp_idx] <= rdata;
    end
  end

  always_comb begin
    h_data      = data_q[head];
    h_addr      = addr_q[head];
    h_byte      = h_data[{h_addr, 3'b000} +: 8];
    h_half      = h_addr[1] ? h_data[31:16] : h_data[15:0];
    out_result  = h_data;
    out_rf_we   = {4{gr_we_q[head]}};
    out_payload = payload_q[head];
    case (op_q[head])
      3'd1: out_result = {{24{h_byte[7]}}, h_byte};
      3'd2: out_result = {24'd0, h_byte};
      3'd3: out_result = {{16{h_half[15]}}, h_half};
      3'd4: out_result = {16'd0, h_half};
      3'd5: begin
        out_result = h_data << {~h_addr, 3'b000};
        out_rf_we  = 4'b1111 << ~h_addr;
      end
      3'd6: begin
        out_result = h_data >> {h_addr, 3'b000};
        out_rf_we  = 4'b1111 >> h_addr;
      end
      default: out_result = h_data;
    endcase
  end

endmodule

// File: tb/tb_mem_resp_queue.sv
// Bench for mem_resp_queue: directed scenarios plus random traffic, all checked against
// a queue-based model of the response queue.
module tb_mem_resp_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid, in_allowin, in_wait_data, in_gr_we;
  logic [2:0]    in_op;
  logic [1:0]    in_addr_low;
  logic [31:0]   in_alu_result, rdata, out_result;
  logic [PW-1:0] in_payload, out_payload;
  logic          data_ok, out_valid, out_allowin, flush, full, empty, resp_err;
  logic [3:0]    out_rf_we;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    bit            pending;
    logic [2:0]    op;
    logic [1:0]    a;
    bit            we;
    logic [31:0]   alu;
    logic [31:0]   rd;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t mq[$];
  int   m_drop = 0;
  bit   m_err  = 1'b0;

  mem_resp_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_wait_data(in_wait_data),
    .in_op(in_op), .in_addr_low(in_addr_low), .in_gr_we(in_gr_we),
    .in_alu_result(in_alu_result), .in_payload(in_payload),
    .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_result(out_result),
    .out_rf_we(out_rf_we), .out_payload(out_payload),
    .flush(flush), .full(full), .empty(empty), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_out_valid();
    return resetn && (mq.size() > 0) && !mq[0].pending;
  endfunction

  function automatic bit m_full();
    return resetn && (mq.size() == DEPTH);
  endfunction

  function automatic bit m_allowin();
    return !m_full() || (m_out_valid() && out_allowin);
  endfunction

  function automatic int m_outstanding();
    int n = m_drop;
    foreach (mq[k]) if (mq[k].pending) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_result(ent_t e);
    logic [31:0] r;
    int ia = int'(e.a);
    case (e.op)
      3'd0: r = e.rd;
      3'd1: begin r = (e.rd >> (8 * ia)) & 32'hFF; if (r[7]) r = r | 32'hFFFF_FF00; end
      3'd2: r = (e.rd >> (8 * ia)) & 32'hFF;
      3'd3: begin r = (e.rd >> (16 * (ia / 2))) & 32'hFFFF; if (r[15]) r = r | 32'hFFFF_0000; end
      3'd4: r = (e.rd >> (16 * (ia / 2))) & 32'hFFFF;
      3'd5: r = e.rd << (8 * (3 - ia));
      3'd6: r = e.rd >> (8 * ia);
      default: r = e.alu;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] m_rf_we(ent_t e);
    if (e.op == 3'd5) begin
      case (e.a)
        2'd0: return 4'b1000;
        2'd1: return 4'b1100;
        2'd2: return 4'b1110;
        default: return 4'b1111;
      endcase
    end
    if (e.op == 3'd6) begin
      case (e.a)
        2'd0: return 4'b1111;
        2'd1: return 4'b0111;
        2'd2: return 4'b0011;
        default: return 4'b0001;
      endcase
    end
    return e.we ? 4'b1111 : 4'b0000;
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    bit ov = m_out_valid();
    check_val("out_valid", 64'(out_valid), 64'(ov));
    check_val("in_allowin", 64'(in_allowin), 64'(m_allowin()));
    check_val("full", 64'(full), 64'(m_full()));
    check_val("empty", 64'(empty), 64'(!resetn || (mq.size() == 0)));
    check_val("resp_err", 64'(resp_err), 64'(m_err));
    check_val("drop_cnt", 64'(dut.drop_cnt), 64'(m_drop));
    if (ov) begin
      check_val("out_result", 64'(out_result), 64'(m_result(mq[0])));
      check_val("out_rf_we", 64'(out_rf_we), 64'(m_rf_we(mq[0])));
      check_val("out_payload", 64'(out_payload), 64'(mq[0].pl));
    end
  endtask

  task automatic model_update();
    bit   ov = m_out_valid();
    bit   al = m_allowin();
    bit   pushing, popping;
    int   j, pc;
    ent_t e;
    if (!resetn) begin
      mq.delete();
      m_drop = 0;
      m_err  = 1'b0;
      return;
    end
    pushing = in_valid && al;
    popping = ov && out_allowin;
    if (data_ok) begin
      if (m_drop > 0) m_drop--;
      else begin
        j = -1;
        foreach (mq[k]) if (j < 0 && mq[k].pending) j = k;
        if (j >= 0) begin
          mq[j].pending = 1'b0;
          mq[j].rd      = rdata;
        end else m_err = 1'b1;
      end
    end
    if (flush) begin
      pc = 0;
      foreach (mq[k]) if (mq[k].pending) pc++;
      m_drop = m_drop + pc + ((pushing && in_wait_data) ? 1 : 0);
      if (m_drop > DEPTH) m_drop = DEPTH;
      mq.delete();
    end else begin
      if (popping) void'(mq.pop_front());
      if (pushing) begin
        e.pending = in_wait_data;
        e.op      = in_op;
        e.a       = in_addr_low;
        e.we      = in_gr_we;
        e.alu     = in_alu_result;
        e.rd      = 32'd0;
        e.pl      = in_payload;
        mq.push_back(e);
      end
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare, then advance the model.
  task automatic applyStimulus(input bit v, input bit w, input logic [2:0] op,
                               input logic [1:0] a, input bit we, input logic [31:0] alu,
                               input bit dok, input logic [31:0] rd, input bit oa,
                               input bit fl);
    in_valid      = v;
    in_wait_data  = w;
    in_op         = op;
    in_addr_low   = a;
    in_gr_we      = we;
    in_alu_result = alu;
    in_payload    = {$urandom, $urandom};
    data_ok       = dok;
    rdata         = rd;
    out_allowin   = oa;
    flush         = fl;
    #1;
    checkOutput();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input bit oa);
    applyStimulus(0, 0, 3'd0, 2'd0, 0, 32'd0, 0, 32'd0, oa, 0);
  endtask

  task automatic push_ld(input logic [2:0] op, input logic [1:0] a, input logic [31:0] alu);
    applyStimulus(1, 1, op, a, 1, alu, 0, 32'd0, 0, 0);
  endtask

  task automatic resp(input logic [31:0] rd);
    applyStimulus(0, 0, 3'd0, 2'd0, 0, 32'd0, 1, rd, 0, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle(0);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 0; in_wait_data = 0; in_op = 0; in_addr_low = 0; in_gr_we = 0;
    in_alu_result = 0; in_payload = 0; data_ok = 0; rdata = 0; out_allowin = 0; flush = 0;
    @(negedge clk);
    idle(0);
    idle(1);
    resetn = 1'b1;

    // Sign-extended LB from the top byte.
    push_ld(3'd1, 2'd3, 32'h0);
    idle(0);
    resp(32'h80FF_FFFF);
    check_val("lb_valid", 64'(out_valid), 64'd1);
    check_val("lb_result", 64'(out_result), 64'hFFFF_FF80);
    check_val("lb_rf_we", 64'(out_rf_we), 64'hF);

    // Fill to DEPTH, complete in order, then pop and push together while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_ld(3'd0, 2'd0, 32'h0);
    check_val("fill_full", 64'(full), 64'd1);
    check_val("fill_allowin", 64'(in_allowin), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      resp(32'hA000_0001 + 32'(i));
      if (i == 0) check_val("fill_first", 64'(out_result), 64'hA000_0001);
    end
    applyStimulus(1, 1, 3'd0, 2'd0, 1, 32'h0, 0, 32'd0, 1, 0);
    check_val("swap_full", 64'(full), 64'd1);
    check_val("swap_head", 64'(out_result), 64'hA000_0002);

    // Flush with two responses still owed, then a fresh load gets the third.
    do_reset();
    for (int i = 0; i < 3; i++) push_ld(3'd0, 2'd0, 32'h0);
    resp(32'h1111_1111);
    applyStimulus(0, 0, 3'd0, 2'd0, 0, 32'd0, 0, 32'd0, 0, 1);
    check_val("flush_drop", 64'(dut.drop_cnt), 64'd2);
    check_val("flush_empty", 64'(empty), 64'd1);
    check_val("flush_valid", 64'(out_valid), 64'd0);
    resp(32'h2222_2222);
    resp(32'h3333_3333);
    check_val("drained_drop", 64'(dut.drop_cnt), 64'd0);
    check_val("drained_err", 64'(resp_err), 64'd0);
    push_ld(3'd0, 2'd0, 32'h0);
    resp(32'hC0DE_0003);
    check_val("after_flush_valid", 64'(out_valid), 64'd1);
    check_val("after_flush_result", 64'(out_result), 64'hC0DE_0003);

    // Unaligned LWL/LWR.
    do_reset();
    push_ld(3'd5, 2'd1, 32'h0);
    resp(32'h1122_3344);
    check_val("lwl_result", 64'(out_result), 64'h3344_0000);
    check_val("lwl_rf_we", 64'(out_rf_we), 64'hC);
    idle(1);
    push_ld(3'd6, 2'd2, 32'h0);
    resp(32'h1122_3344);
    check_val("lwr_result", 64'(out_result), 64'h0000_1122);
    check_val("lwr_rf_we", 64'(out_rf_we), 64'h3);

    // Stray response is sticky until reset.
    do_reset();
    resp(32'h0);
    check_val("stray_err", 64'(resp_err), 64'd1);
    repeat (3) idle(0);
    check_val("stray_sticky", 64'(resp_err), 64'd1);
    do_reset();
    check_val("stray_cleared", 64'(resp_err), 64'd0);

    // Reset abandons pending loads without arming drops.
    push_ld(3'd0, 2'd0, 32'h0);
    push_ld(3'd0, 2'd0, 32'h0);
    do_reset();
    check_val("rst_empty", 64'(empty), 64'd1);
    check_val("rst_drop", 64'(dut.drop_cnt), 64'd0);
    resp(32'h0);
    check_val("rst_stray_err", 64'(resp_err), 64'd1);
    do_reset();

    // Random traffic; responses only arrive while something is owed.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] op;
      bit         w;
      op = 3'($urandom_range(0, 7));
      w  = (op != 3'd7) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 99) < 60, w, op, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom,
                    (m_outstanding() > 0) && ($urandom_range(0, 99) < 40), $urandom,
                    $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
